// File: rtl/alu_decode_stage_pkg.sv
// alu_decode_stage_pkg: shared constants for the RV32I decode stage.
//   - ALU opcode encodings consumed by execute (ALU_OP_NONE = 6'h3F)
//   - RV32I major opcodes recognised by the decoder
package alu_decode_stage_pkg;

  // ALU opcodes
  localparam logic [5:0] ALU_ADD     = 6'h00;
  localparam logic [5:0] ALU_SUB     = 6'h01;
  localparam logic [5:0] ALU_SLL     = 6'h02;
  localparam logic [5:0] ALU_SLT     = 6'h03;
  localparam logic [5:0] ALU_SLTU    = 6'h04;
  localparam logic [5:0] ALU_XOR     = 6'h05;
  localparam logic [5:0] ALU_SRL     = 6'h06;
  localparam logic [5:0] ALU_SRA     = 6'h07;
  localparam logic [5:0] ALU_OR      = 6'h08;
  localparam logic [5:0] ALU_AND     = 6'h09;
  localparam logic [5:0] ALU_ADDI    = 6'h0A;
  localparam logic [5:0] ALU_SLTI    = 6'h0B;
  localparam logic [5:0] ALU_SLTIU   = 6'h0C;
  localparam logic [5:0] ALU_XORI    = 6'h0D;
  localparam logic [5:0] ALU_ORI     = 6'h0E;
  localparam logic [5:0] ALU_ANDI    = 6'h0F;
  localparam logic [5:0] ALU_SLLI    = 6'h10;
  localparam logic [5:0] ALU_SRLI    = 6'h11;
  localparam logic [5:0] ALU_SRAI    = 6'h12;
  localparam logic [5:0] ALU_OP_NONE = 6'h3F;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/rv32_alu_decoder.sv
// rv32_alu_decoder: purely combinational RV32I decode of one instruction word.
// Ports:
//   instr           in   32-bit instruction word
//   alu_op          out  ALU opcode (ALU_OP_NONE when no ALU work / illegal)
//   rs1/rs2/rd      out  register indices (rs1 forced to x0 for LUI)
//   imm             out  sign-extended immediate (zero-extended shamt for shifts)
//   use_imm         out  operand b taken from imm
//   we              out  rd write enable (never set for rd = x0)
//   illegal         out  unsupported encoding
module rv32_alu_decoder
  import alu_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [5:0]      alu_op,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            use_imm,
  output logic            we,
  output logic            illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    alu_op  = ALU_OP_NONE;
    rs1     = instr[19:15];
    rs2     = instr[24:20];
    rd      = instr[11:7];
    imm     = '0;
    use_imm = 1'b0;
    we      = 1'b0;
    illegal = 1'b0;

    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      unique case (opc)
        OPC_OP: begin
          we = 1'b1;
          if (f7 == F7_ZERO) begin
            unique case (f3)
              3'b000: alu_op = ALU_ADD;
              3'b001: alu_op = ALU_SLL;
              3'b010: alu_op = ALU_SLT;
              3'b011: alu_op = ALU_SLTU;
              3'b100: alu_op = ALU_XOR;
              3'b101: alu_op = ALU_SRL;
              3'b110: alu_op = ALU_OR;
              default: alu_op = ALU_AND;
            endcase
          end else if (f7 == F7_ALT && f3 == 3'b000) begin
            alu_op = ALU_SUB;
          end else if (f7 == F7_ALT && f3 == 3'b101) begin
            alu_op = ALU_SRA;
          end else begin
            illegal = 1'b1;
          end
        end
        OPC_OP_IMM: begin
          we      = 1'b1;
          use_imm = 1'b1;
          imm     = XLEN'(signed'(instr[31:20]));
          unique case (f3)
            3'b000: alu_op = ALU_ADDI;
            3'b010: alu_op = ALU_SLTI;
            3'b011: alu_op = ALU_SLTIU;
            3'b100: alu_op = ALU_XORI;
            3'b110: alu_op = ALU_ORI;
            3'b111: alu_op = ALU_ANDI;
            3'b001: begin
              imm = XLEN'(instr[24:20]);
              if (f7 == F7_ZERO) alu_op = ALU_SLLI;
              else               illegal = 1'b1;
            end
            default: begin // 3'b101: funct7 picks logical vs arithmetic
              imm = XLEN'(instr[24:20]);
              if (f7 == F7_ZERO)     alu_op = ALU_SRLI;
              else if (f7 == F7_ALT) alu_op = ALU_SRAI;
              else                   illegal = 1'b1;
            end
          endcase
        end
        OPC_LUI: begin
          alu_op  = ALU_ADD;   // x0 + upper immediate
          rs1     = 5'd0;
          imm     = XLEN'(signed'({instr[31:12], 12'b0}));
          use_imm = 1'b1;
          we      = 1'b1;
        end
        OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
        OPC_AUIPC, OPC_MISC_MEM, OPC_SYSTEM: begin
          // legal but no ALU work in this stage; fields already raw
        end
        default: illegal = 1'b1;
      endcase
    end

    // Illegal encodings carry no ALU side effects
    if (illegal) begin
      alu_op  = ALU_OP_NONE;
      imm     = '0;
      use_imm = 1'b0;
      we      = 1'b0;
    end
    if (rd == 5'd0) we = 1'b0;
  end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I decode pipeline stage between fetch and execute.
// Accepts an instruction over valid/ready, decodes it with rv32_alu_decoder
// and presents one registered bundle per instruction.
// Ports:
//   clk, rst_n (async active-low), flush (sync kill of held entries)
//   in_valid/in_ready/in_instr/in_pc          fetch side
//   out_valid/out_ready/out_*                 execute side
//   illegal_cnt                               saturating count of accepted illegals
// Build option: DECODE_SKID_EN replaces the single register with a 2-entry
// skid buffer so in_ready no longer depends combinationally on out_ready.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [5:0]      out_alu_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_use_imm,
  output logic            out_we,
  output logic            out_illegal,
  output logic [15:0]     illegal_cnt
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [5:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            we;
    logic            illegal;
  } entry_t;

  localparam entry_t ENTRY_RST = '{pc: '0, alu_op: ALU_OP_NONE, rs1: '0, rs2: '0,
                                   rd: '0, imm: '0, use_imm: 1'b0, we: 1'b0,
                                   illegal: 1'b0};

  entry_t      in_ent, main_q;
  logic        main_vld_q;
  logic        in_fire;
  logic [15:0] illegal_cnt_q;

  assign in_ent.pc = in_pc;

  rv32_alu_decoder #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .alu_op  (in_ent.alu_op),
    .rs1     (in_ent.rs1),
    .rs2     (in_ent.rs2),
    .rd      (in_ent.rd),
    .imm     (in_ent.imm),
    .use_imm (in_ent.use_imm),
    .we      (in_ent.we),
    .illegal (in_ent.illegal)
  );

  assign in_fire = in_valid && in_ready;

`ifdef DECODE_SKID_EN
  entry_t skid_q;
  logic   skid_vld_q;

  assign in_ready = !skid_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= ENTRY_RST;
      skid_q     <= ENTRY_RST;
    end else if (flush) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (skid_vld_q) begin
      // skid only fills behind a valid head; in_ready is low meanwhile
      if (out_ready) begin
        main_q     <= skid_q;
        skid_vld_q <= 1'b0;
      end
    end else if (!main_vld_q || out_ready) begin
      main_vld_q <= in_valid;
      if (in_valid) main_q <= in_ent;
    end else if (in_valid) begin
      // head stalled: park the in-flight entry
      skid_q     <= in_ent;
      skid_vld_q <= 1'b1;
    end
  end
`else
  assign in_ready = !main_vld_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      main_q     <= ENTRY_RST;
    end else if (flush) begin
      main_vld_q <= 1'b0;
    end else begin
      if (in_ready) main_vld_q <= in_valid;
      if (in_fire)  main_q     <= in_ent;
    end
  end
`endif

  // Flushed transfers are dropped, so they are not counted either
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else if (in_fire && !flush && in_ent.illegal && illegal_cnt_q != 16'hFFFF) begin
      illegal_cnt_q <= illegal_cnt_q + 16'd1;
    end
  end

  assign out_valid   = main_vld_q;
  assign out_pc      = main_q.pc;
  assign out_alu_op  = main_q.alu_op;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_imm     = main_q.imm;
  assign out_use_imm = main_q.use_imm;
  assign out_we      = main_q.we;
  assign out_illegal = main_q.illegal;
  assign illegal_cnt = illegal_cnt_q;

endmodule
